// File: rtl/bram_table_loader.sv
// bram_table_loader
//   Writer side of a masked S-box table BRAM. Streams DEPTH table bytes into
//   one write-enabled BRAM port (entries 0..DEPTH-1). It then reads every
//   entry back through the same port and compares the read-back sum/xor with
//   the write-side sum/xor. The result is a one-cycle done pulse or a sticky
//   error.
//
// Ports
//   clk, rst_n      clock, async active-low reset
//   start           begin a load (sampled in IDLE/DONE/ERROR only)
//   in_data/valid   table byte stream, entry order 0..DEPTH-1
//   in_ready        loader accepts a beat this cycle
//   bram_en/we      BRAM port enable / write enable
//   bram_addr/di    BRAM port address / write data
//   bram_do         BRAM read data, valid RD_LAT cycles after its address
//   busy            WRITE or VERIFY in progress
//   done            one-cycle pulse, verify passed
//   error           sticky verify mismatch, cleared by the next start
module bram_table_loader #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 1024,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              bram_en,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_di,
  input  logic [DATA_W-1:0] bram_do,
  output logic              busy,
  output logic              done,
  output logic              error
);

  // One extra bit so counters reach DEPTH without wrapping.
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic [2:0] {IDLE, WRITE, VERIFY, DONE, ERROR} st_t;

  st_t               st;
  logic [CW-1:0]     wcnt, rcnt, ccnt;
  logic [15:0]       wsum, rsum;
  logic [DATA_W-1:0] wxor, rxor;
  // vld_pipe[0] is high while a read address is on the port. vld_pipe[RD_LAT]
  // is high in the cycle its data is on bram_do.
  logic [RD_LAT:0]   vld_pipe;
  logic              cmp;      // compare cycle: all captures accumulated
  logic              acc;
  logic              rd_go;

  assign acc   = in_valid & in_ready;
  assign rd_go = (st == VERIFY) && (rcnt != FULL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= IDLE;
      in_ready  <= 1'b0;
      bram_en   <= 1'b0;
      bram_we   <= 1'b0;
      bram_addr <= '0;
      bram_di   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      wcnt      <= '0;
      rcnt      <= '0;
      ccnt      <= '0;
      wsum      <= '0;
      rsum      <= '0;
      wxor      <= '0;
      rxor      <= '0;
      vld_pipe  <= '0;
      cmp       <= 1'b0;
    end else begin
      done     <= 1'b0;
      bram_en  <= 1'b0;
      bram_we  <= 1'b0;
      vld_pipe <= {vld_pipe[RD_LAT-1:0], rd_go};

      if (vld_pipe[RD_LAT]) begin
        rsum <= rsum + 16'(bram_do);
        rxor <= rxor ^ bram_do;
        ccnt <= ccnt + ONE;
        if (ccnt == LAST) cmp <= 1'b1;
      end

      case (st)
        IDLE, DONE, ERROR: begin
          if (start) begin
            st       <= WRITE;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            error    <= 1'b0;
            wcnt     <= '0;
            rcnt     <= '0;
            ccnt     <= '0;
            wsum     <= '0;
            rsum     <= '0;
            wxor     <= '0;
            rxor     <= '0;
            vld_pipe <= '0;
            cmp      <= 1'b0;
          end else if (st == DONE) begin
            st <= IDLE;
          end
        end

        WRITE: begin
          if (acc) begin
            bram_en   <= 1'b1;
            bram_we   <= 1'b1;
            bram_addr <= ADDR_W'(wcnt);
            bram_di   <= in_data;
            wcnt      <= wcnt + ONE;
            wsum      <= wsum + 16'(in_data);
            wxor      <= wxor ^ in_data;
            if (wcnt == LAST) begin
              in_ready <= 1'b0;
              st       <= VERIFY;
            end
          end
        end

        VERIFY: begin
          if (rd_go) begin
            bram_en   <= 1'b1;
            bram_addr <= ADDR_W'(rcnt);
            rcnt      <= rcnt + ONE;
          end
          if (cmp) begin
            cmp  <= 1'b0;
            busy <= 1'b0;
            if (rsum == wsum && rxor == wxor) begin
              st   <= DONE;
              done <= 1'b1;
            end else begin
              st    <= ERROR;
              error <= 1'b1;
            end
          end
        end

        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_table_loader.sv
// tb_bram_table_loader
//   Drives full table loads into bram_table_loader against a 2-cycle BRAM
//   model. Expected writes are queued as beats are accepted and popped as
//   the DUT issues BRAM writes. A vector table covers clean, corrupted,
//   gappy and start-spammed loads. Hand-written sequences cover reset
//   mid-load and in_valid while idle.
module tb_bram_table_loader;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 1024;
  localparam int RD_LAT = 2;
  localparam int LAT    = 2 * DEPTH + RD_LAT + 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              bram_en, bram_we;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_di;
  logic [DATA_W-1:0] bram_do;
  logic              busy, done, error;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bit flip = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bram_table_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_di(bram_di), .bram_do(bram_do), .busy(busy), .done(done), .error(error)
  );

  // BRAM port model: address register + output register; optional bit0 flip at 0x155.
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] ra = '0;
  always @(posedge clk) begin
    if (bram_en && bram_we) mem[bram_addr] <= bram_di;
    ra      <= bram_addr;
    bram_do <= mem[ra] ^ ((flip && ra == 10'h155) ? 8'h01 : 8'h00);
  end

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    int gap_pct;
    bit spam;
    bit flip;
    int exp_done;
    bit exp_err;
    bit chk_lat;
  } vec_t;

  function automatic logic [DATA_W-1:0] fk(input int k);
    return 8'((k & 'hFF) ^ 'h5A);
  endfunction

  task automatic check(input string nm, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : sb_mon
    sb_t e;
    if (rst_n && bram_en && bram_we) begin
      if (sb.size() == 0) check("sb_unexpected_write", {bram_addr, bram_di}, 0);
      else begin
        e = sb.pop_front();
        check("wr_addr", bram_addr, e.a);
        check("wr_data", bram_di, e.d);
      end
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1 start = 1'b0;
    check("start_state", {busy, in_ready, error}, 3'b110);
  endtask

  task automatic run_load(input vec_t v);
    int k, acc_c, done_c, tail, dn;
    bit fin;
    k = 0; acc_c = 0; done_c = 0; tail = 0; dn = 0; fin = 1'b0;
    flip = v.flip;
    pulse_start();
    for (int c = 0; c < 12000 && tail < 20; c++) begin
      if (k < DEPTH && $urandom_range(99) >= v.gap_pct) begin
        in_valid = 1'b1; in_data = fk(k);
      end else begin
        in_valid = 1'b0; in_data = 8'(~fk(k));
      end
      start = v.spam && busy && ($urandom_range(7) == 0);
      @(negedge clk);
      if (in_valid && in_ready) begin
        sb.push_back({ADDR_W'(k), in_data});
        if (k == 0) acc_c = cyc;
        k++;
      end
      if (done) begin dn++; done_c = cyc; end
      if (done || error) fin = 1'b1;
      if (fin) tail++;
      @(posedge clk); #1;
    end
    start = 1'b0; in_valid = 1'b0;
    check("load_finished", fin, 1);
    check("beats_accepted", k, DEPTH);
    check("sb_drained", sb.size(), 0);
    check("done_pulses", dn, v.exp_done);
    check("error_final", error, v.exp_err);
    check("busy_final", busy, 0);
    if (v.chk_lat) check("done_latency", done_c - acc_c, LAT);
  endtask

  task automatic abort_load(input int at);
    int k;
    k = 0;
    flip = 1'b0;
    pulse_start();
    for (int c = 0; c < 4000; c++) begin
      in_valid = 1'b1; in_data = fk(k);
      @(negedge clk);
      if (in_valid && in_ready) begin
        sb.push_back({ADDR_W'(k), in_data});
        k++;
      end
      if (k == at) break;
      @(posedge clk); #1;
    end
    check("abort_reached", k, at);
    #2 rst_n = 1'b0;
    #1 check("async_reset_outputs",
             {in_ready, bram_en, bram_we, bram_addr, bram_di, busy, done, error}, 0);
    sb.delete();
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
  endtask

  vec_t vecs [5];
  int bad;

  initial begin
    vecs[0] = '{gap_pct: 0,  spam: 0, flip: 0, exp_done: 1, exp_err: 0, chk_lat: 1};
    vecs[1] = '{gap_pct: 0,  spam: 0, flip: 1, exp_done: 0, exp_err: 1, chk_lat: 0};
    vecs[2] = '{gap_pct: 0,  spam: 0, flip: 0, exp_done: 1, exp_err: 0, chk_lat: 1};
    vecs[3] = '{gap_pct: 50, spam: 0, flip: 0, exp_done: 1, exp_err: 0, chk_lat: 0};
    vecs[4] = '{gap_pct: 0,  spam: 1, flip: 0, exp_done: 1, exp_err: 0, chk_lat: 1};

    #12;
    check("reset_outputs",
          {in_ready, bram_en, bram_we, bram_addr, bram_di, busy, done, error}, 0);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      run_load(vecs[i]);
      bad = 0;
      for (int a = 0; a < DEPTH; a++) if (mem[a] !== fk(a)) bad++;
      check("mem_contents", bad, 0);
    end

    // Reset after 300 beats, then a clean reload from address 0.
    abort_load(300);
    run_load(vecs[0]);

    // in_valid held high while idle: no ready, no writes, stays idle.
    bad = 0;
    in_valid = 1'b1; in_data = 8'hAA;
    repeat (20) begin
      @(negedge clk);
      if (in_ready || bram_en || busy || done) bad++;
    end
    in_valid = 1'b0;
    check("idle_ignores_valid", bad, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
